// File: rtl/icache_pkg.sv
// Shared types and default sizing for the instruction cache.
package icache_pkg;

    // Default geometry: 64 single-word lines, 32-bit addresses and words.
    localparam int ICACHE_LINE_NUM   = 64;
    localparam int ICACHE_ADDR_WIDTH = 32;
    localparam int ICACHE_DATA_WIDTH = 32;

    // Controller state: idle/lookup, or waiting on the memory fill.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } icache_state_e;

    // Clears the byte-offset bits of a fetch address (word alignment).
    function automatic logic [ICACHE_ADDR_WIDTH-1:0] word_align(
        input logic [ICACHE_ADDR_WIDTH-1:0] addr
    );
        logic [ICACHE_ADDR_WIDTH-1:0] mask;
        mask = ~{{(ICACHE_ADDR_WIDTH-2){1'b0}}, 2'b11};
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Hits answer one cycle after the request; misses fetch a single word from
// the memory controller, fill the line and answer on the fill edge.
// Only one request is ever outstanding, so lookup and fill never collide.
module icache
    import icache_pkg::*;
#(
    parameter int LINE_NUM = ICACHE_LINE_NUM
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         valid_from_inst_fetcher,
    input  logic [ICACHE_ADDR_WIDTH-1:0] addr_from_inst_fetcher,
    output logic                         ready_to_inst_fetcher,
    output logic [ICACHE_DATA_WIDTH-1:0] data_to_inst_fetcher,
    output logic                         valid_to_mem_ctrler,
    output logic [ICACHE_ADDR_WIDTH-1:0] addr_to_mem_ctrler,
    input  logic                         ready_from_mem_ctrler,
    input  logic [ICACHE_DATA_WIDTH-1:0] data_from_mem_ctrler
);

    localparam int INDEX_BITS = $clog2(LINE_NUM);
    localparam int TAG_BITS   = ICACHE_ADDR_WIDTH - INDEX_BITS - 2;

    // Line storage; only the valid vector is cleared by reset.
    logic [LINE_NUM-1:0]          r_valid;
    logic [TAG_BITS-1:0]          r_tag_arr  [LINE_NUM];
    logic [ICACHE_DATA_WIDTH-1:0] r_data_arr [LINE_NUM];

    // Controller and output registers.
    icache_state_e                r_state;
    logic                         r_ready;
    logic [ICACHE_DATA_WIDTH-1:0] r_data_out;
    logic                         r_mem_valid;
    logic [ICACHE_ADDR_WIDTH-1:0] r_mem_addr;

    // Next-state values.
    icache_state_e                w_state_nxt;
    logic                         w_ready_nxt;
    logic [ICACHE_DATA_WIDTH-1:0] w_data_out_nxt;
    logic                         w_mem_valid_nxt;
    logic [ICACHE_ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic                         w_fill_en;

    // Address decode for the live request and for the captured miss.
    logic [ICACHE_ADDR_WIDTH-1:0] w_req_aligned;
    logic [INDEX_BITS-1:0]        w_req_idx;
    logic [TAG_BITS-1:0]          w_req_tag;
    logic [INDEX_BITS-1:0]        w_fill_idx;
    logic [TAG_BITS-1:0]          w_fill_tag;
    logic                         w_hit;

    assign w_req_aligned = word_align(addr_from_inst_fetcher);
    assign w_req_idx     = w_req_aligned[INDEX_BITS+1:2];
    assign w_req_tag     = w_req_aligned[ICACHE_ADDR_WIDTH-1:INDEX_BITS+2];
    // The fill always targets the line of the address captured at miss time,
    // even if the requester misbehaves and changes its address during WAIT.
    assign w_fill_idx    = r_mem_addr[INDEX_BITS+1:2];
    assign w_fill_tag    = r_mem_addr[ICACHE_ADDR_WIDTH-1:INDEX_BITS+2];
    assign w_hit         = r_valid[w_req_idx] && (r_tag_arr[w_req_idx] == w_req_tag);

    // Next-state and next-output logic for the lookup/fill controller.
    always_comb begin
        w_state_nxt     = r_state;
        w_ready_nxt     = 1'b0;
        w_data_out_nxt  = r_data_out;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_addr_nxt  = r_mem_addr;
        w_fill_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The !r_ready term stops a held request from re-triggering
                // in the cycle its answer is visible to the requester.
                if (valid_from_inst_fetcher && !r_ready) begin
                    if (w_hit) begin
                        w_ready_nxt    = 1'b1;
                        w_data_out_nxt = r_data_arr[w_req_idx];
                    end else begin
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addr_nxt  = w_req_aligned;
                        w_state_nxt     = ST_WAIT;
                    end
                end else begin
                    w_ready_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                if (ready_from_mem_ctrler) begin
                    w_fill_en       = 1'b1;
                    w_data_out_nxt  = data_from_mem_ctrler;
                    w_ready_nxt     = 1'b1;
                    w_mem_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_mem_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_mem_valid_nxt = 1'b0;
            end
        endcase
    end

    // Controller, output and valid-bit registers; rdy low freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_data_out  <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_valid     <= '0;
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_ready     <= w_ready_nxt;
            r_data_out  <= w_data_out_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            if (w_fill_en) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; written only on a fill, never reset.
    always_ff @(posedge clk) begin
        if (rdy && w_fill_en) begin
            r_tag_arr[w_fill_idx]  <= w_fill_tag;
            r_data_arr[w_fill_idx] <= data_from_mem_ctrler;
        end
    end

    assign ready_to_inst_fetcher = r_ready;
    assign data_to_inst_fetcher  = r_data_out;
    assign valid_to_mem_ctrler   = r_mem_valid;
    assign addr_to_mem_ctrler    = r_mem_addr;

endmodule
